// File: rtl/risc_result_fifo_if.sv
// Result-port bundle between the RISC core, the result FIFO and the SoC result bus.
// The slave view belongs to the FIFO. The master view belongs to whatever drives the core side and consumes the result bus.
interface risc_result_fifo_if #(
    parameter int unsigned DW = 16,
    parameter int unsigned TW = 8
);
    logic          OUT_VALID;
    logic [DW-1:0] RESULT_DATA;
    logic [10:0]   PSW;
    logic          Res_Ready;
    logic          Res_Valid;
    logic [DW-1:0] Res_Data;
    logic [TW-1:0] Res_Tag;

    modport slave (
        input  OUT_VALID, RESULT_DATA, PSW, Res_Ready,
        output Res_Valid, Res_Data, Res_Tag
    );

    modport master (
        output OUT_VALID, RESULT_DATA, PSW, Res_Ready,
        input  Res_Valid, Res_Data, Res_Tag
    );
endinterface

// File: rtl/risc_result_fifo.sv
// Result FIFO for the RISC core. It stores each result word together with its PC tag and drains it over valid/ready.
// The core has no stall input, so a push into a full FIFO is dropped and counted.
module risc_result_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned DW    = 16,
    parameter int unsigned TW    = 8,
    parameter int unsigned CW    = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    risc_result_fifo_if.slave    res,
    input  logic                 Clr_Ovfl,
    output logic [CW-1:0]        Res_Count,
    output logic                 Fifo_Full,
    output logic                 Ovfl_Flag,
    output logic [7:0]           Drop_Cnt
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic {EMPTY, HOLD} state_t;

    state_t              state_q, state_d;
    logic [TW+DW-1:0]    mem_q [DEPTH];
    logic [AW-1:0]       wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]       count_q, count_d, count_left;
    logic                full_q, full_d;
    logic                ovfl_q, ovfl_d;
    logic [7:0]          drop_q, drop_d;
    logic [TW+DW-1:0]    head_q, head_d;
    logic [TW+DW-1:0]    wr_word;
    logic                push, pop, acc, drop;

    always_comb begin
        wr_word    = {res.PSW[10:3], res.RESULT_DATA};
        push       = res.OUT_VALID;
        pop        = (state_q == HOLD) & res.Res_Ready;
        acc        = push & (~full_q | pop);
        drop       = push & full_q & ~pop;
        wr_d       = wr_q + AW'(acc);
        rd_d       = rd_q + AW'(pop);
        count_d    = count_q + CW'(acc) - CW'(pop);
        count_left = count_q - CW'(pop);
        full_d     = (count_d == CW'(DEPTH));

        // The head register is loaded one cycle ahead. If nothing is left after the pop, the word being written this cycle becomes the head.
        head_d = (count_left == '0) ? wr_word : mem_q[rd_d];

        ovfl_d = ovfl_q;
        drop_d = drop_q;
        if (Clr_Ovfl) begin
            ovfl_d = 1'b0;
            drop_d = '0;
        end
        if (drop) begin
            ovfl_d = 1'b1;
            drop_d = Clr_Ovfl ? 8'd1 : ((drop_q == 8'hFF) ? 8'hFF : drop_q + 8'd1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (acc) state_d = HOLD;
            HOLD:  if (pop && count_q == CW'(1) && !acc) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            ovfl_q  <= 1'b0;
            drop_q  <= '0;
            head_q  <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            full_q  <= full_d;
            ovfl_q  <= ovfl_d;
            drop_q  <= drop_d;
            head_q  <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (acc) mem_q[wr_q] <= wr_word;
    end

    always_comb begin
        res.Res_Valid = (state_q == HOLD);
        res.Res_Data  = res.Res_Valid ? head_q[DW-1:0]     : '0;
        res.Res_Tag   = res.Res_Valid ? head_q[TW+DW-1:DW] : '0;
        Res_Count     = count_q;
        Fifo_Full     = full_q;
        Ovfl_Flag     = ovfl_q;
        Drop_Cnt      = drop_q;
    end
endmodule

// File: tb/tb_risc_result_fifo.sv
// Directed bench for risc_result_fifo. Each step samples the outputs 1ns after the rising edge and compares them with hand-computed values.
module tb_risc_result_fifo;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       Clr_Ovfl;
    logic [3:0] Res_Count;
    logic       Fifo_Full;
    logic       Ovfl_Flag;
    logic [7:0] Drop_Cnt;
    int unsigned errors = 0;
    int unsigned checks = 0;

    risc_result_fifo_if #(.DW(16), .TW(8)) res_if ();

    risc_result_fifo #(.DEPTH(8), .DW(16), .TW(8), .CW(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .res       (res_if.slave),
        .Clr_Ovfl  (Clr_Ovfl),
        .Res_Count (Res_Count),
        .Fifo_Full (Fifo_Full),
        .Ovfl_Flag (Ovfl_Flag),
        .Drop_Cnt  (Drop_Cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic [7:0] pc);
        res_if.OUT_VALID   = v;
        res_if.RESULT_DATA = d;
        res_if.PSW         = {pc, 3'b101};
    endtask

    initial begin
        // 1: reset held with a pending push
        reset_n = 1'b0;
        Clr_Ovfl = 1'b0;
        res_if.Res_Ready = 1'b0;
        drive(1'b1, 16'h55AA, 8'h33);
        repeat (2) cyc();
        chk("rst_valid", res_if.Res_Valid, 0);
        chk("rst_data", res_if.Res_Data, 0);
        chk("rst_tag", res_if.Res_Tag, 0);
        chk("rst_count", Res_Count, 0);
        chk("rst_full", Fifo_Full, 0);
        chk("rst_ovfl", Ovfl_Flag, 0);
        chk("rst_drop", Drop_Cnt, 0);
        reset_n = 1'b1;
        cyc();
        chk("t1_valid", res_if.Res_Valid, 1);
        chk("t1_data", res_if.Res_Data, 16'h55AA);
        chk("t1_tag", res_if.Res_Tag, 8'h33);
        chk("t1_count", Res_Count, 1);
        drive(1'b0, 16'h0, 8'h0);
        res_if.Res_Ready = 1'b1;
        cyc();
        chk("t1_empty", res_if.Res_Valid, 0);

        // 2: single push
        drive(1'b1, 16'hBEEF, 8'h12);
        cyc();
        chk("t2_valid", res_if.Res_Valid, 1);
        chk("t2_data", res_if.Res_Data, 16'hBEEF);
        chk("t2_tag", res_if.Res_Tag, 8'h12);
        drive(1'b0, 16'h0, 8'h0);
        cyc();
        chk("t2_valid_gone", res_if.Res_Valid, 0);
        chk("t2_count", Res_Count, 0);

        // 3: fill, then overflow
        res_if.Res_Ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 16'(i), 8'(i));
            cyc();
        end
        chk("t3_full", Fifo_Full, 1);
        chk("t3_count", Res_Count, 8);
        chk("t3_head", res_if.Res_Data, 1);
        chk("t3_head_tag", res_if.Res_Tag, 1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'hDEAD, 8'hEE);
            cyc();
        end
        chk("t3_ovfl", Ovfl_Flag, 1);
        chk("t3_drop", Drop_Cnt, 3);
        chk("t3_count_kept", Res_Count, 8);
        chk("t3_head_kept", res_if.Res_Data, 1);

        // 4: push and pop together while full
        drive(1'b1, 16'h0009, 8'h09);
        res_if.Res_Ready = 1'b1;
        cyc();
        drive(1'b0, 16'h0, 8'h0);
        chk("t4_count", Res_Count, 8);
        chk("t4_drop", Drop_Cnt, 3);
        chk("t4_full", Fifo_Full, 1);
        for (int k = 2; k <= 9; k++) begin
            chk("t4_drain_valid", res_if.Res_Valid, 1);
            chk("t4_drain_data", res_if.Res_Data, 32'(k));
            chk("t4_drain_tag", res_if.Res_Tag, 32'(k));
            cyc();
        end
        chk("t4_empty", res_if.Res_Valid, 0);
        chk("t4_count0", Res_Count, 0);
        chk("t4_full0", Fifo_Full, 0);

        // 5: streaming with three entries held, pointers wrap
        res_if.Res_Ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'(200 + i), 8'(i));
            cyc();
        end
        chk("t5_head0", res_if.Res_Data, 200);
        chk("t5_count0", Res_Count, 3);
        res_if.Res_Ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 16'(203 + i), 8'(i));
            cyc();
            chk("t5_valid", res_if.Res_Valid, 1);
            chk("t5_data", res_if.Res_Data, 32'(201 + i));
            chk("t5_count", Res_Count, 3);
        end
        drive(1'b0, 16'h0, 8'h0);
        for (int i = 0; i < 3; i++) begin
            chk("t5_tail", res_if.Res_Data, 32'(220 + i));
            cyc();
        end
        chk("t5_empty", res_if.Res_Valid, 0);

        // 6: saturating drop counter and clear priority
        res_if.Res_Ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 16'(300 + i), 8'hA0);
            cyc();
        end
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 16'hFFFF, 8'hFF);
            cyc();
        end
        chk("t6_sat", Drop_Cnt, 255);
        chk("t6_ovfl", Ovfl_Flag, 1);
        chk("t6_count", Res_Count, 8);
        chk("t6_head", res_if.Res_Data, 300);
        Clr_Ovfl = 1'b1;
        cyc();
        chk("t6_clr_drop_ovfl", Ovfl_Flag, 1);
        chk("t6_clr_drop_cnt", Drop_Cnt, 1);
        drive(1'b0, 16'h0, 8'h0);
        cyc();
        chk("t6_clr_ovfl", Ovfl_Flag, 0);
        chk("t6_clr_cnt", Drop_Cnt, 0);
        Clr_Ovfl = 1'b0;

        // reset while full: Res_Valid falls without a clock edge
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_valid", res_if.Res_Valid, 0);
        chk("rst_mid_count", Res_Count, 0);
        chk("rst_mid_full", Fifo_Full, 0);
        cyc();
        reset_n = 1'b1;
        cyc();
        chk("rst_mid_after", res_if.Res_Valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
